// File: rtl/ir_key_pkg.sv
// Shared key-code constants, FSM state encoding and digit decode for the IR keypad controller.
package ir_key_pkg;

  localparam logic [7:0] KEY_D0    = 8'h16;
  localparam logic [7:0] KEY_D1    = 8'h0C;
  localparam logic [7:0] KEY_D2    = 8'h18;
  localparam logic [7:0] KEY_D3    = 8'h5E;
  localparam logic [7:0] KEY_D4    = 8'h08;
  localparam logic [7:0] KEY_D5    = 8'h1C;
  localparam logic [7:0] KEY_D6    = 8'h5A;
  localparam logic [7:0] KEY_D7    = 8'h42;
  localparam logic [7:0] KEY_D8    = 8'h52;
  localparam logic [7:0] KEY_D9    = 8'h4A;
  localparam logic [7:0] KEY_PLUS  = 8'h15;
  localparam logic [7:0] KEY_MINUS = 8'h07;
  localparam logic [7:0] KEY_OK    = 8'h40;
  localparam logic [7:0] KEY_CLR   = 8'h44;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Returns {hit, digit}; hit is 0 for any non-digit code.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      KEY_D0:  r = 5'h10;
      KEY_D1:  r = 5'h11;
      KEY_D2:  r = 5'h12;
      KEY_D3:  r = 5'h13;
      KEY_D4:  r = 5'h14;
      KEY_D5:  r = 5'h15;
      KEY_D6:  r = 5'h16;
      KEY_D7:  r = 5'h17;
      KEY_D8:  r = 5'h18;
      KEY_D9:  r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd4_incdec.sv
// Four-digit BCD increment/decrement by one; wraps 9999->0000 and 0000->9999.
module bcd4_incdec
  import ir_key_pkg::*;
(
  input  logic [15:0] value,
  input  logic        down,
  output logic [15:0] result
);

  always_comb begin
    logic       carry;
    logic [3:0] d;
    result = 16'h0000;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = value[i*4 +: 4];
      if (!carry) begin
        result[i*4 +: 4] = d;
      end else if (down) begin
        result[i*4 +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
        carry            = (d == 4'd0);
      end else begin
        result[i*4 +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
        carry            = (d == 4'd9);
      end
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// IR remote keypad controller: 4-digit BCD entry, commit, +/- stepping with NEC repeat, entry timeout.
//
// state     | meaning
// ST_IDLE   | showing committed value; digits start entry, +/-/CLR edit committed value
// ST_ENTRY  | building the entry buffer; OK commits, timeout abandons
// ST_COMMIT | one cycle while commit_pulse is high; key events dropped
module ir_key_ctrl
  import ir_key_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  input  logic        key_repeat,
  output logic [15:0] disp_data,
  output logic        entry_active,
  output logic        commit_pulse,
  output logic        led
);

  localparam int unsigned TO_CYCLES = TIMEOUT_MS * (CLK_FREQ / 1000);
  localparam int          TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TO_CYCLES - 1);

  state_t          state;
  logic [15:0]     entry_buf;
  logic [15:0]     committed;
  logic [7:0]      last_key;
  logic [TO_W-1:0] to_cnt;

  logic [4:0]  dig;
  logic        is_dig, is_plus, is_minus, is_ok, is_clr, is_mapped;
  logic        last_step, rep_hit, step_down;
  logic [15:0] stepped;

  always_comb begin
    dig       = decode_digit(key_code);
    is_dig    = dig[4];
    is_plus   = (key_code == KEY_PLUS);
    is_minus  = (key_code == KEY_MINUS);
    is_ok     = (key_code == KEY_OK);
    is_clr    = (key_code == KEY_CLR);
    is_mapped = is_dig | is_plus | is_minus | is_ok | is_clr;
    last_step = (last_key == KEY_PLUS) || (last_key == KEY_MINUS);
    // key_valid takes priority, so a simultaneous repeat never gets a second step
    rep_hit   = key_repeat && !key_valid && (state == ST_IDLE) && last_step;
    step_down = key_valid ? is_minus : (last_key == KEY_MINUS);
  end

  bcd4_incdec u_incdec (
    .value  (committed),
    .down   (step_down),
    .result (stepped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      entry_buf    <= 16'h0000;
      committed    <= 16'h0000;
      last_key     <= 8'h00;
      to_cnt       <= '0;
      disp_data    <= 16'h0000;
      entry_active <= 1'b0;
      commit_pulse <= 1'b0;
      led          <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      entry_active <= (state == ST_ENTRY);
      led          <= (committed != 16'h0000);
      disp_data    <= (state == ST_ENTRY) ? entry_buf : committed;

      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            to_cnt <= TO_RELOAD;
            if (is_mapped) last_key <= key_code;
            if (is_dig) begin
              entry_buf <= {12'h000, dig[3:0]};
              state     <= ST_ENTRY;
            end else if (is_plus || is_minus) begin
              committed    <= stepped;
              commit_pulse <= 1'b1;
            end else if (is_clr) begin
              committed    <= 16'h0000;
              commit_pulse <= 1'b1;
            end
          end else if (key_repeat) begin
            to_cnt <= TO_RELOAD;
            if (rep_hit) begin
              committed    <= stepped;
              commit_pulse <= 1'b1;
            end
          end
        end

        ST_ENTRY: begin
          if (key_valid) begin
            to_cnt <= TO_RELOAD;
            if (is_mapped) last_key <= key_code;
            if (is_dig) begin
              entry_buf <= {entry_buf[11:0], dig[3:0]};
            end else if (is_ok) begin
              committed    <= entry_buf;
              commit_pulse <= 1'b1;
              state        <= ST_COMMIT;
            end else if (is_clr) begin
              entry_buf <= 16'h0000;
            end
          end else if (key_repeat) begin
            to_cnt <= TO_RELOAD;
          end else if (to_cnt == '0) begin
            entry_buf <= 16'h0000;
            state     <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end

        ST_COMMIT: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl with a 20-cycle entry timeout.
module tb_ir_key_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_valid = 1'b0;
  logic        key_repeat = 1'b0;
  logic [15:0] disp_data;
  logic        entry_active;
  logic        commit_pulse;
  logic        led;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int p0;

  localparam logic [7:0] K0 = 8'h16, K1 = 8'h0C, K2 = 8'h18, K3 = 8'h5E, K4 = 8'h08;
  localparam logic [7:0] K5 = 8'h1C, K7 = 8'h42, K8 = 8'h52, K9 = 8'h4A;
  localparam logic [7:0] KP = 8'h15, KM = 8'h07, KOK = 8'h40, KCLR = 8'h44;

  ir_key_ctrl #(.CLK_FREQ(20_000), .TIMEOUT_MS(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_repeat   (key_repeat),
    .disp_data    (disp_data),
    .entry_active (entry_active),
    .commit_pulse (commit_pulse),
    .led          (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (commit_pulse) pulses++;

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    key_code = c; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_rep();
    @(negedge clk);
    key_repeat = 1'b1;
    @(negedge clk);
    key_repeat = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] c);
    send_key(c);
    settle();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL reset_disp got=%h exp=%h", disp_data, 16'h0000); end
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL reset_entry got=%b exp=0", entry_active); end
    total++; if (commit_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", commit_pulse); end
    total++; if (led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", led); end
  endtask

  task automatic test_entry();
    key(K1); key(K2); key(K3); key(K4); key(K5);
    total++; if (disp_data !== 16'h2345) begin bad++; $display("FAIL entry_disp got=%h exp=%h", disp_data, 16'h2345); end
    total++; if (entry_active !== 1'b1) begin bad++; $display("FAIL entry_active got=%b exp=1", entry_active); end
    p0 = pulses;
    key(KOK);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL commit_once got=%0d exp=1", pulses - p0); end
    total++; if (disp_data !== 16'h2345) begin bad++; $display("FAIL commit_disp got=%h exp=%h", disp_data, 16'h2345); end
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL commit_idle got=%b exp=0", entry_active); end
    total++; if (led !== 1'b1) begin bad++; $display("FAIL commit_led got=%b exp=1", led); end
    p0 = pulses;
    key(KOK);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL idle_ok got=%0d exp=0", pulses - p0); end
  endtask

  task automatic test_plus_minus();
    key(K9); key(K9); key(K9); key(K9); key(KOK);
    total++; if (disp_data !== 16'h9999) begin bad++; $display("FAIL set_9999 got=%h exp=%h", disp_data, 16'h9999); end
    p0 = pulses;
    key(KP);
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL wrap_up got=%h exp=%h", disp_data, 16'h0000); end
    total++; if (led !== 1'b0) begin bad++; $display("FAIL wrap_led got=%b exp=0", led); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL plus_pulse got=%0d exp=1", pulses - p0); end
    key(KM);
    total++; if (disp_data !== 16'h9999) begin bad++; $display("FAIL wrap_down got=%h exp=%h", disp_data, 16'h9999); end
    key(KM);
    send_rep(); settle(); send_rep(); settle(); send_rep(); settle();
    total++; if (disp_data !== 16'h9995) begin bad++; $display("FAIL minus_rep got=%h exp=%h", disp_data, 16'h9995); end
    p0 = pulses;
    key(KCLR);
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL idle_clr got=%h exp=%h", disp_data, 16'h0000); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL clr_pulse got=%0d exp=1", pulses - p0); end
    key(K0); key(K1); key(K9); key(K9); key(KOK);
    key(KP);
    total++; if (disp_data !== 16'h0200) begin bad++; $display("FAIL carry_up got=%h exp=%h", disp_data, 16'h0200); end
    key(KM);
    total++; if (disp_data !== 16'h0199) begin bad++; $display("FAIL borrow_down got=%h exp=%h", disp_data, 16'h0199); end
  endtask

  task automatic test_timeout();
    p0 = pulses;
    key(K7);
    total++; if (disp_data !== 16'h0007) begin bad++; $display("FAIL to_entry got=%h exp=%h", disp_data, 16'h0007); end
    repeat (10) @(negedge clk);
    total++; if (entry_active !== 1'b1) begin bad++; $display("FAIL to_early got=%b exp=1", entry_active); end
    repeat (20) @(negedge clk);
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL to_expired got=%b exp=0", entry_active); end
    total++; if (disp_data !== 16'h0199) begin bad++; $display("FAIL to_disp got=%h exp=%h", disp_data, 16'h0199); end
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL to_pulse got=%0d exp=0", pulses - p0); end
  endtask

  task automatic test_repeat_and_ignore();
    key(K8);
    send_rep(); settle();
    total++; if (disp_data !== 16'h0008) begin bad++; $display("FAIL digit_rep got=%h exp=%h", disp_data, 16'h0008); end
    key(KCLR);
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL entry_clr got=%h exp=%h", disp_data, 16'h0000); end
    total++; if (entry_active !== 1'b1) begin bad++; $display("FAIL entry_clr_stay got=%b exp=1", entry_active); end
    key(KP);
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL entry_plus got=%h exp=%h", disp_data, 16'h0000); end
    repeat (9) @(negedge clk);
    send_key(8'hFF);
    repeat (14) @(negedge clk);
    total++; if (entry_active !== 1'b1) begin bad++; $display("FAIL unmapped_reload got=%b exp=1", entry_active); end
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL unmapped_disp got=%h exp=%h", disp_data, 16'h0000); end
    repeat (25) @(negedge clk);
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL unmapped_timeout got=%b exp=0", entry_active); end
    key(KP);
    total++; if (disp_data !== 16'h0200) begin bad++; $display("FAIL idle_plus got=%h exp=%h", disp_data, 16'h0200); end
    p0 = pulses;
    @(negedge clk);
    key_code = KP; key_valid = 1'b1; key_repeat = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_repeat = 1'b0;
    settle();
    total++; if (disp_data !== 16'h0201) begin bad++; $display("FAIL both_single got=%h exp=%h", disp_data, 16'h0201); end
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL both_pulse got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_back_to_back();
    key(K3);
    send_key(KOK);
    key_code = K5; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    settle();
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL commit_drop_state got=%b exp=0", entry_active); end
    total++; if (disp_data !== 16'h0003) begin bad++; $display("FAIL commit_drop_disp got=%h exp=%h", disp_data, 16'h0003); end
  endtask

  task automatic test_reset_mid_entry();
    key(K4); key(K2);
    total++; if (disp_data !== 16'h0042) begin bad++; $display("FAIL pre_rst got=%h exp=%h", disp_data, 16'h0042); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (disp_data !== 16'h0000) begin bad++; $display("FAIL rst_disp got=%h exp=%h", disp_data, 16'h0000); end
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL rst_entry got=%b exp=0", entry_active); end
    total++; if (led !== 1'b0) begin bad++; $display("FAIL rst_led got=%b exp=0", led); end
    total++; if (commit_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%b exp=0", commit_pulse); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();
    total++; if (entry_active !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", entry_active); end
    key(KP);
    total++; if (disp_data !== 16'h0001) begin bad++; $display("FAIL rst_committed got=%h exp=%h", disp_data, 16'h0001); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_plus_minus();
    test_timeout();
    test_repeat_and_ignore();
    test_back_to_back();
    test_reset_mid_entry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_key_ctrl.md
IR_KEY_CTRL -- requirements
Module: ir_key_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_MS, default 5000, entry-abandon timeout in ms.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port key_code  input  8  NEC command byte from the IR decoder.
REQ-006 SHALL have port key_valid  input  1  one-cycle strobe, new key frame, key_code valid.
REQ-007 SHALL have port key_repeat  input  1  one-cycle strobe, NEC repeat frame.
REQ-008 SHALL have port disp_data  output  16  four BCD digits to the tube driver; [3:0] is the rightmost digit.
REQ-009 SHALL have port entry_active  output  1  high while in ENTRY.
REQ-010 SHALL have port commit_pulse  output  1  one-cycle strobe when the committed value is updated.
REQ-011 SHALL have port led  output  1  high when the committed value != 0.

Function
REQ-012 Key map SHALL be: digits 0-9 = 16,0C,18,5E,08,1C,5A,42,52,4A (hex); PLUS = 15; MINUS = 07; OK = 40; CLR = 44; all other codes are ignored and do not alter last_key.
REQ-013 FSM states SHALL be IDLE, ENTRY and COMMIT.
REQ-014 IDLE + digit d: entry buffer SHALL become {12'h000, d}; next state ENTRY.
REQ-015 ENTRY + digit d: buffer SHALL shift left one nibble, dropping the top nibble and inserting d at [3:0].
REQ-016 ENTRY + OK: next state COMMIT; in COMMIT, committed value <= buffer, commit_pulse = 1 for exactly that cycle; next state IDLE.
REQ-017 IDLE + OK SHALL be ignored.
REQ-018 ENTRY + CLR: buffer SHALL clear to 0000 and the state SHALL remain ENTRY; IDLE + CLR: committed value <= 0000 with commit_pulse.
REQ-019 IDLE + PLUS/MINUS: committed value SHALL be BCD +1/-1, with wrap 9999->0000 and 0000->9999, and commit_pulse asserted; in ENTRY, PLUS/MINUS SHALL be ignored.
REQ-020 key_repeat SHALL reapply PLUS/MINUS when last_key is PLUS/MINUS and the state is IDLE, and SHALL otherwise be ignored (no digit auto-repeat).
REQ-021 key_valid and key_repeat in the same cycle: key_valid SHALL win and key_repeat SHALL be dropped.
REQ-022 Timeout counter SHALL reload on every accepted key_valid/key_repeat; when TIMEOUT_MS*(CLK_FREQ/1000) cycles elapse in ENTRY, the block SHALL return to IDLE with the buffer discarded and no commit_pulse.
REQ-023 disp_data SHALL equal the buffer in ENTRY and the committed value otherwise; it SHALL be registered, with 1-cycle latency from state/value change.
REQ-024 Key events arriving during the COMMIT cycle SHALL be dropped.
REQ-025 entry_active and led SHALL be registered outputs.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously enter state IDLE, clear the buffer, committed value, last_key and timeout counter to 0, and drive disp_data=0000, entry_active=0, commit_pulse=0, led=0.
REQ-027 Reset mid-ENTRY or mid-COMMIT SHALL lose all entry data with no commit_pulse.
REQ-028 Operation SHALL resume on the first clk edge after rst_n deasserts.

Structure
REQ-029 Key-code constants and the state encoding SHALL live in shared package ir_key_pkg.
REQ-030 BCD +/-1 with wrap SHALL be the single sub-module bcd4_incdec (16-bit in, dir, 16-bit out, combinational).
REQ-031 Timeout width SHALL be derived with $clog2 from the parameters.

Verification
REQ-032 Keys 1,2,3,4,5 then OK SHALL give disp_data 2345 during ENTRY, commit_pulse once, then 2345 committed and led=1.
REQ-033 Committed 9999 + PLUS SHALL give 0000 with led=0; then MINUS SHALL give 9999; MINUS followed by 3 repeats SHALL give 9995.
REQ-034 Key 7 then idle for TIMEOUT SHALL return to IDLE with the old committed value shown and no commit_pulse (TIMEOUT_MS=1 for simulation).
REQ-035 Key 8 followed by a repeat frame SHALL leave the buffer at 0008; key_valid(PLUS) together with key_repeat in IDLE SHALL apply a single +1.
REQ-036 rst_n pulse while in ENTRY with buffer 0042 SHALL give all outputs 0 immediately, state IDLE and committed value 0000.
REQ-037 An unmapped code (e.g. 0xFF) in ENTRY SHALL change nothing and SHALL reload the timeout counter.
